// File: rtl/hd_sync_gen.sv
// HD raster timing generator: fractional-NCO pixel clock, h/v counters with registered
// sync decode, and a frame-lock FSM that snaps the line counter to the PAL frame end.
module hd_sync_gen #(
    parameter int unsigned H_ACT       = 1280,
    parameter int unsigned H_FP        = 8,
    parameter int unsigned H_SYNC      = 32,
    parameter int unsigned H_BP        = 40,
    parameter int unsigned V_ACT       = 720,
    parameter int unsigned V_FP        = 3,
    parameter int unsigned V_SYNC      = 5,
    parameter int unsigned V_BP        = 20,
    parameter int unsigned NCO_INC     = 32768,
    parameter int unsigned V_LOCK_LINE = 740,
    parameter int unsigned LOCK_TOL    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_lock_en,
    input  logic        i_frame_end,
    output logic        o_hd_clk,
    output logic        o_pix_en,
    output logic        o_hd_hsync,
    output logic        o_hd_vsync,
    output logic        o_hd_de,
    output logic        o_locked,
    output logic [11:0] o_h_cnt,
    output logic [10:0] o_v_cnt
);

    localparam int unsigned H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [16:0] INC     = 17'(NCO_INC);
    localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT_W = 12'(H_ACT);
    localparam logic [10:0] V_ACT_W = 11'(V_ACT);
    localparam logic [11:0] HS_BEG  = 12'(H_ACT + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACT + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_ACT + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACT + V_FP + V_SYNC);
    localparam logic [10:0] V_LOCK  = 11'(V_LOCK_LINE);
    localparam logic [11:0] V_TOT_W = 12'(V_TOTAL);
    localparam logic [11:0] TOL_W   = 12'(LOCK_TOL);
    localparam logic [11:0] WD_LAST = 12'(2 * V_TOTAL - 1);

    typedef enum logic [1:0] {FREE, SEEK, LOCKED} lock_state_t;

    logic [15:0] r_acc;
    logic [16:0] w_sum;
    logic        w_tick;
    logic        w_pix;
    logic        w_wrap;
    logic        w_snap;
    logic        r_hd_clk;
    logic        r_pix_en;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic        r_locked;
    logic        r_pending;
    logic [11:0] r_h_cnt;
    logic [11:0] w_h_nxt;
    logic [10:0] r_v_cnt;
    logic [10:0] w_v_nxt;
    logic [11:0] r_wd;
    logic [11:0] w_diff;
    logic [11:0] w_err;
    lock_state_t r_state;
    lock_state_t w_state_nxt;

    assign w_sum  = {1'b0, r_acc} + INC;
    assign w_tick = w_sum[16];
    assign w_pix  = w_tick & r_hd_clk;
    assign w_wrap = w_pix && (r_h_cnt == H_LAST);
    // A frame end seen in the wrap cycle only sets pending; the old flag decides this wrap.
    assign w_snap = w_wrap & r_pending & i_lock_en;

    always_comb begin
        w_h_nxt = r_h_cnt;
        w_v_nxt = r_v_cnt;
        if (w_wrap) begin
            w_h_nxt = '0;
            if (w_snap)
                w_v_nxt = V_LOCK;
            else if (r_v_cnt == V_LAST)
                w_v_nxt = '0;
            else
                w_v_nxt = r_v_cnt + 11'd1;
        end else if (w_pix) begin
            w_h_nxt = r_h_cnt + 12'd1;
        end
    end

    // Circular line distance to the lock line.
    assign w_diff = (r_v_cnt >= V_LOCK) ? {1'b0, r_v_cnt - V_LOCK} : {1'b0, V_LOCK - r_v_cnt};
    assign w_err  = (w_diff <= V_TOT_W - w_diff) ? w_diff : V_TOT_W - w_diff;

    always_comb begin
        w_state_nxt = r_state;
        if (!i_lock_en) begin
            w_state_nxt = FREE;
        end else begin
            if (r_state == FREE)
                w_state_nxt = SEEK;
            if (i_frame_end) begin
                if (w_err <= TOL_W)
                    w_state_nxt = LOCKED;
                else
                    w_state_nxt = SEEK;
            end else if (r_state == LOCKED && w_wrap && r_wd == WD_LAST) begin
                w_state_nxt = SEEK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_hd_clk <= 1'b0;
            r_pix_en <= 1'b0;
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_de     <= 1'b0;
        end else begin
            r_acc    <= w_sum[15:0];
            r_pix_en <= w_pix;
            if (w_tick)
                r_hd_clk <= ~r_hd_clk;
            if (w_pix) begin
                r_h_cnt <= w_h_nxt;
                r_v_cnt <= w_v_nxt;
                r_hsync <= (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END);
                r_vsync <= (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END);
                r_de    <= (w_h_nxt < H_ACT_W) && (w_v_nxt < V_ACT_W);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= SEEK;
            r_locked  <= 1'b0;
            r_pending <= 1'b0;
            r_wd      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_locked <= (w_state_nxt == LOCKED);
            if (!i_lock_en)
                r_pending <= 1'b0;
            else if (i_frame_end)
                r_pending <= 1'b1;
            else if (w_snap)
                r_pending <= 1'b0;
            if (r_state != LOCKED || i_frame_end)
                r_wd <= '0;
            else if (w_wrap)
                r_wd <= r_wd + 12'd1;
        end
    end

    assign o_hd_clk   = r_hd_clk;
    assign o_pix_en   = r_pix_en;
    assign o_hd_hsync = r_hsync;
    assign o_hd_vsync = r_vsync;
    assign o_hd_de    = r_de;
    assign o_locked   = r_locked;
    assign o_h_cnt    = r_h_cnt;
    assign o_v_cnt    = r_v_cnt;

endmodule

// File: tb/tb_hd_sync_gen.sv
// Bench for hd_sync_gen: a reduced-raster instance checked cycle by cycle against an
// arithmetic pixel/line model, plus a default-parameter instance for full-size line timing.
module tb_hd_sync_gen;

    localparam int     HT  = 25;
    localparam int     VT  = 20;
    localparam int     VL  = 18;
    localparam int     TOL = 2;
    localparam int     HA  = 16;
    localparam int     VA  = 12;
    localparam int     HS0 = 18;
    localparam int     HS1 = 22;
    localparam int     VS0 = 14;
    localparam int     VS1 = 17;
    localparam longint INC = 32768;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic lock_en = 1'b0;
    logic frame_end = 1'b0;

    logic        o_hd_clk, o_pix_en, o_hd_hsync, o_hd_vsync, o_hd_de, o_locked;
    logic [11:0] o_h_cnt;
    logic [10:0] o_v_cnt;
    logic        d_hd_clk, d_pix_en, d_hsync, d_vsync, d_de, d_locked;
    logic [11:0] d_h_cnt;
    logic [10:0] d_v_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hd_sync_gen #(
        .H_ACT(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACT(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
        .NCO_INC(32768), .V_LOCK_LINE(18), .LOCK_TOL(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_lock_en(lock_en), .i_frame_end(frame_end),
        .o_hd_clk(o_hd_clk), .o_pix_en(o_pix_en), .o_hd_hsync(o_hd_hsync),
        .o_hd_vsync(o_hd_vsync), .o_hd_de(o_hd_de), .o_locked(o_locked),
        .o_h_cnt(o_h_cnt), .o_v_cnt(o_v_cnt)
    );

    hd_sync_gen dut_hd (
        .clk(clk), .reset_n(reset_n), .i_lock_en(1'b0), .i_frame_end(1'b0),
        .o_hd_clk(d_hd_clk), .o_pix_en(d_pix_en), .o_hd_hsync(d_hsync),
        .o_hd_vsync(d_vsync), .o_hd_de(d_de), .o_locked(d_locked),
        .o_h_cnt(d_h_cnt), .o_v_cnt(d_v_cnt)
    );

    // Reference model: pixel count derived from the NCO phase, line number from a base
    // line/offset pair that a snap re-anchors.
    longint m_n = 0, m_p = 0, m_vbase = 0, m_lbase = 0;
    int     m_state = 1;   // 0 free, 1 seek, 2 locked
    int     m_wd = 0;
    bit     m_pend = 0, m_pix = 0, m_any = 0;

    function automatic longint pixc(longint n);
        return ((n * INC) >> 16) / 2;
    endfunction

    function automatic int vline(longint p, longint vb, longint lb);
        return int'((vb + p / HT - lb) % VT);
    endfunction

    function automatic int lock_err(int v);
        int d;
        d = ((v - VL) % VT + VT) % VT;
        return (d <= VT - d) ? d : VT - d;
    endfunction

    longint      x_pn;
    bit          x_pix, x_wrap, x_snap, e_hdclk, e_hs, e_vs, e_de;
    int          x_err, x_state, e_h, e_v;
    logic [28:0] e_vec, a_vec, d_vec;

    always_comb begin
        e_h     = int'(m_p % HT);
        e_v     = vline(m_p, m_vbase, m_lbase);
        e_hdclk = (((m_n * INC) >> 16) % 2) == 1;
        e_hs    = m_any && e_h >= HS0 && e_h < HS1;
        e_vs    = m_any && e_v >= VS0 && e_v < VS1;
        e_de    = m_any && e_h < HA && e_v < VA;
        e_vec   = {e_hdclk, m_pix, e_hs, e_vs, e_de, m_state == 2, 12'(e_h), 11'(e_v)};
        x_pn    = pixc(m_n + 1);
        x_pix   = x_pn != m_p;
        x_wrap  = x_pix && (x_pn % HT == 0);
        x_snap  = x_wrap && m_pend && lock_en;
        x_err   = lock_err(e_v);
        if (!lock_en) begin
            x_state = 0;
        end else begin
            x_state = (m_state == 0) ? 1 : m_state;
            if (frame_end)
                x_state = (x_err <= TOL) ? 2 : 1;
            else if (x_state == 2 && x_wrap && m_wd + 1 >= 2 * VT)
                x_state = 1;
        end
    end

    assign a_vec = {o_hd_clk, o_pix_en, o_hd_hsync, o_hd_vsync, o_hd_de, o_locked, o_h_cnt, o_v_cnt};
    assign d_vec = {d_hd_clk, d_pix_en, d_hsync, d_vsync, d_de, d_locked, d_h_cnt, d_v_cnt};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_n <= 0; m_p <= 0; m_vbase <= 0; m_lbase <= 0;
            m_state <= 1; m_wd <= 0; m_pend <= 0; m_pix <= 0; m_any <= 0;
        end else begin
            m_n   <= m_n + 1;
            m_p   <= x_pn;
            m_pix <= x_pix;
            if (x_pix)
                m_any <= 1;
            if (x_snap) begin
                m_vbase <= VL;
                m_lbase <= x_pn / HT;
            end
            m_pend  <= !lock_en ? 1'b0 : frame_end ? 1'b1 : x_snap ? 1'b0 : m_pend;
            m_state <= x_state;
            m_wd    <= (frame_end || m_state != 2) ? 0 : x_wrap ? m_wd + 1 : m_wd;
        end
    end

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_vec !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", a_vec); end
        checks++;
        if (d_vec !== '0) begin errors++; $display("FAIL reset_outputs_hd: got %h want 0", d_vec); end
        reset_n = 1'b1;
    endtask

    task automatic test_nco();
        int last = -1;
        int highs = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== e_vec) begin errors++; $display("FAIL nco_vec: got %h want %h", a_vec, e_vec); end
            highs += int'(o_hd_clk);
            if (o_pix_en) begin
                checks++;
                if (!(prev === 1'b1 && o_hd_clk === 1'b0)) begin
                    errors++; $display("FAIL pix_edge: hd_clk %b->%b want 1->0", prev, o_hd_clk);
                end
                if (last >= 0) begin
                    checks++;
                    if (i - last != 4) begin errors++; $display("FAIL pix_period: got %0d want 4", i - last); end
                end
                last = i;
            end
            prev = o_hd_clk;
        end
        checks++;
        if (highs != 20) begin errors++; $display("FAIL hd_clk_duty: high %0d of 40 want 20", highs); end
    endtask

    task automatic test_default_timing();
        int st = 0, t0 = 0, hs_pix = 0, de_pix = 0;
        logic hs_prev;
        hs_prev = d_hsync;
        for (int i = 0; i < 12000 && st < 2; i++) begin
            @(negedge clk);
            if (d_pix_en && d_h_cnt == 0) begin
                if (st == 1) begin
                    checks += 3;
                    if (i - t0 != 5440) begin errors++; $display("FAIL hd_line_clks: got %0d want 5440", i - t0); end
                    if (hs_pix != 32) begin errors++; $display("FAIL hd_hsync_width: got %0d want 32", hs_pix); end
                    if (de_pix != 1280) begin errors++; $display("FAIL hd_de_width: got %0d want 1280", de_pix); end
                    st = 2;
                end else begin
                    st = 1; t0 = i; hs_pix = 0; de_pix = 0;
                end
            end
            if (st == 1 && d_pix_en) begin
                hs_pix += int'(d_hsync);
                de_pix += int'(d_de);
            end
            if (st == 1 && d_hsync && !hs_prev) begin
                checks++;
                if (d_h_cnt !== 12'd1288) begin errors++; $display("FAIL hd_hsync_rise: h %0d want 1288", d_h_cnt); end
            end
            if (st == 1 && !d_hsync && hs_prev) begin
                checks++;
                if (d_h_cnt !== 12'd1320) begin errors++; $display("FAIL hd_hsync_fall: h %0d want 1320", d_h_cnt); end
            end
            hs_prev = d_hsync;
        end
        checks++;
        if (st != 2) begin errors++; $display("FAIL hd_line_timeout: state %0d want 2", st); end
    endtask

    task automatic test_free_run();
        int starts = 0, de_cnt = 0, lines = 0;
        lock_en = 1'b0;
        for (int i = 0; i < 6500 && starts < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== e_vec) begin errors++; $display("FAIL free_vec: got %h want %h", a_vec, e_vec); end
            if (o_pix_en && o_h_cnt == 0 && o_v_cnt == 0) begin
                if (starts > 0) begin
                    checks += 2;
                    if (de_cnt != HA * VA) begin errors++; $display("FAIL free_de_count: got %0d want %0d", de_cnt, HA * VA); end
                    if (lines != VT) begin errors++; $display("FAIL free_frame_lines: got %0d want %0d", lines, VT); end
                end
                starts++; de_cnt = 0; lines = 0;
            end
            if (o_pix_en && o_hd_de) de_cnt++;
            if (o_pix_en && o_h_cnt == 0) lines++;
            frame_end = ($urandom_range(0, 49) == 0);
        end
        frame_end = 1'b0;
        checks++;
        if (starts < 3) begin errors++; $display("FAIL free_timeout: frames %0d want 3", starts); end
    endtask

    task automatic test_seek_snap();
        bit found = 0;
        int seen = 0;
        lock_en = 1'b1;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = (e_v == 5 && e_h == 10);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL seek_wait: line 5 not reached, want reached"); end
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        checks++;
        if (o_locked !== 1'b0) begin errors++; $display("FAIL seek_far: locked %b want 0", o_locked); end
        for (int i = 0; i < 400 && seen < 2; i++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== e_vec) begin errors++; $display("FAIL seek_vec: got %h want %h", a_vec, e_vec); end
            if (o_pix_en && o_h_cnt == 0) begin
                checks++;
                if (o_v_cnt !== (seen == 0 ? 11'd18 : 11'd19)) begin
                    errors++; $display("FAIL seek_snap_line: got %0d want %0d", o_v_cnt, seen == 0 ? 18 : 19);
                end
                seen++;
            end
        end
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = (e_v == 19 && e_h == 5);
        end
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        checks++;
        if (!found || o_locked !== 1'b1) begin errors++; $display("FAIL seek_lock: locked %b found %0b want 1", o_locked, found); end
    endtask

    task automatic test_unlock();
        bit found = 0;
        int starts = 0, pcnt = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = (e_v == 7 && e_h == 12);
        end
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        checks++;
        if (!found || o_locked !== 1'b0) begin errors++; $display("FAIL unlock: locked %b found %0b want 0", o_locked, found); end
        for (int i = 0; i < 600 && starts < 4; i++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== e_vec) begin errors++; $display("FAIL unlock_vec: got %h want %h", a_vec, e_vec); end
            if (o_pix_en && o_h_cnt == 0) begin
                if (starts == 0) begin
                    checks++;
                    if (o_v_cnt !== 11'd18) begin errors++; $display("FAIL unlock_snap: got %0d want 18", o_v_cnt); end
                end else begin
                    checks++;
                    if (pcnt != HT) begin errors++; $display("FAIL line_len: got %0d want %0d", pcnt, HT); end
                end
                starts++; pcnt = 1;
            end else if (o_pix_en) begin
                pcnt++;
            end
        end
        checks++;
        if (starts < 4) begin errors++; $display("FAIL unlock_timeout: lines %0d want 4", starts); end
    endtask

    task automatic test_wrap_coincident();
        bit found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = (e_v == 3 && e_h == HT - 1 && x_pix);
        end
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        checks++;
        if (!found || o_v_cnt !== 11'd4 || o_h_cnt !== 12'd0) begin
            errors++; $display("FAIL wrap_same_cycle: v %0d h %0d found %0b want v 4 h 0", o_v_cnt, o_h_cnt, found);
        end
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = (o_pix_en && o_h_cnt == 0);
        end
        checks++;
        if (!found || o_v_cnt !== 11'd18) begin errors++; $display("FAIL wrap_next_snap: v %0d want 18", o_v_cnt); end
    endtask

    task automatic test_watchdog();
        bit found = 0, done = 0;
        int wraps = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = (e_v == 1 && e_h == 8);
        end
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        checks++;
        if (!found || o_locked !== 1'b0) begin errors++; $display("FAIL tol_plus1: locked %b want 0", o_locked); end
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = (e_v == 0 && e_h == 8);
        end
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        checks++;
        if (!found || o_locked !== 1'b1) begin errors++; $display("FAIL tol_circular: locked %b want 1", o_locked); end
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== e_vec) begin errors++; $display("FAIL wd_vec: got %h want %h", a_vec, e_vec); end
            if (o_pix_en && o_h_cnt == 0) wraps++;
            done = !o_locked;
        end
        checks++;
        if (!done || wraps != 2 * VT) begin errors++; $display("FAIL watchdog: wraps %0d want %0d", wraps, 2 * VT); end
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks += 2;
        if (a_vec !== '0) begin errors++; $display("FAIL async_reset: got %h want 0", a_vec); end
        if (d_vec !== '0) begin errors++; $display("FAIL async_reset_hd: got %h want 0", d_vec); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        lock_en = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            checks++;
            if (a_vec !== e_vec) begin errors++; $display("FAIL rnd_vec: got %h want %h", a_vec, e_vec); end
            if ($urandom_range(0, 399) == 0) lock_en = ~lock_en;
            frame_end = ($urandom_range(0, 119) == 0);
        end
        frame_end = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nco();
        test_default_timing();
        test_free_run();
        test_seek_snap();
        test_unlock();
        test_wrap_coincident();
        test_watchdog();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hd_sync_gen.md
Name: hd_sync_gen

Overview:
- Generates the HD raster timing (pixel clock level, hsync, vsync, data enable) from the system clock for the PAL-to-HD upsampler, which consumes `o_hd_clk`, `o_hd_hsync` and `o_hd_vsync`.
- Pixel rate comes from a fractional NCO.
- Frame-locks the HD raster to the PAL source by snapping the vertical counter on the upsampler's `o_frame_end` pulse, so line-buffer read and write stay in phase.
- Reports lock status.

Parameters:
- `H_ACT`, 1280, active pixels per line
- `H_FP`, 8, horizontal front porch (pixels)
- `H_SYNC`, 32, hsync width (pixels)
- `H_BP`, 40, horizontal back porch (pixels); `H_TOTAL` = sum = 1360
- `V_ACT`, 720, active lines
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 5, vsync width (lines)
- `V_BP`, 20, vertical back porch (lines); `V_TOTAL` = sum = 748
- `NCO_INC`, 32768, 17-bit half-pixel increment added to a 16-bit accumulator; carry = half-pixel tick; 65536 = tick every clk
- `V_LOCK_LINE`, 740, line loaded into `v_cnt` on frame lock
- `LOCK_TOL`, 2, max line error (circular) at `i_frame_end` still counted as locked

Ports:
- `clk`  in  1  system clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `i_lock_en`  in  1  1 = frame lock to `i_frame_end` enabled; 0 = free-run
- `i_frame_end`  in  1  single-cycle pulse from upsampler at PAL vsync falling edge
- `o_hd_clk`  out  1  pixel clock level; falling edge marks a pixel
- `o_pix_en`  out  1  one-cycle strobe, coincident with the cycle `o_hd_clk` goes 1->0
- `o_hd_hsync`  out  1  active-high hsync
- `o_hd_vsync`  out  1  active-high vsync
- `o_hd_de`  out  1  active video
- `o_locked`  out  1  raster locked to PAL frame
- `o_h_cnt`  out  12  current pixel index
- `o_v_cnt`  out  11  current line index

Behaviour:
- Reset (`reset_n`=0, async): accumulator, `h_cnt`, `v_cnt`, all outputs = 0; state = SEEK; pending flag = 0. Release resumes counting from 0,0. Reset mid-frame aborts any pending snap.
- NCO:
  - `acc` (16 b) <= `acc` + `NCO_INC` each clk; carry out = tick.
  - `o_hd_clk` toggles on each tick.
  - `o_pix_en`=1 exactly on ticks where `o_hd_clk` goes 1->0.
  - Pixel period = 2*65536/`NCO_INC` clks (default 4).
- Counters advance only on `o_pix_en`:
  - `h_cnt` wraps `H_TOTAL`-1 -> 0.
  - On that wrap, `v_cnt` <= `v_cnt`+1, wrapping `V_TOTAL`-1 -> 0, unless a snap applies.
- Sync decode, registered; updated in the same cycle as the counter update and computed from the new counter values:
  - `hsync` = `h_cnt` in [`H_ACT`+`H_FP`, `H_ACT`+`H_FP`+`H_SYNC`).
  - `vsync` = `v_cnt` in [`V_ACT`+`V_FP`, `V_ACT`+`V_FP`+`V_SYNC`).
  - `de` = `h_cnt` < `H_ACT` && `v_cnt` < `V_ACT`.
  - All three are stable between `pix_en` strobes.
- Lock FSM, states FREE, SEEK, LOCKED:
  - `i_lock_en`=0 -> FREE; `i_frame_end` ignored; pending cleared; `o_locked`=0.
  - `i_lock_en` 0->1 -> SEEK.
  - On `i_frame_end` with `i_lock_en`=1:
    - `err` = min(|`v_cnt`-`V_LOCK_LINE`|, `V_TOTAL`-|`v_cnt`-`V_LOCK_LINE`|).
    - Set pending.
    - SEEK: `err`<=`LOCK_TOL` -> LOCKED.
    - LOCKED: `err`>`LOCK_TOL` -> SEEK.
  - Snap: at the next `h_cnt` wrap after pending is set, `v_cnt` <= `V_LOCK_LINE` instead of +1; pending cleared. Snap never occurs mid-line, so no partial lines.
  - `i_frame_end` in the same cycle as an h wrap: not applied on that wrap; applied on the following wrap.
  - Second `i_frame_end` while pending: `err`/state evaluated again, still a single snap.
  - Watchdog: in LOCKED, 2*`V_TOTAL` line wraps with no `i_frame_end` -> SEEK. Counter resets on each `i_frame_end`.
  - `o_locked` = (state==LOCKED), registered.
- Widths: `h_cnt` 12 b, `v_cnt` 11 b, watchdog 12 b. Parameters are legal if `H_TOTAL`<4096 and `V_TOTAL`<2048.

Test Plan:
- Reset, `NCO_INC`=32768 -> `o_pix_en` every 4 clks; `o_hd_clk` period 4 clks, 50% duty; `hsync` high for `h_cnt` 1288..1319; line = 5440 clks.
- Free-run, `i_lock_en`=0 -> `vsync` high for lines 723..727; frame = 748 lines; `de` high 1280x720 pixels/frame; `i_frame_end` pulses have no effect.
- `i_lock_en`=1, `i_frame_end` at `v_cnt`=100 -> state stays SEEK; next line is 740 then 741; next `i_frame_end` arriving at `v_cnt`=741 (`err`=1) -> `o_locked`=1.
- LOCKED, `i_frame_end` at `v_cnt`=300 -> `o_locked`=0 the next cycle, snap to 740, no line shorter than 1360 pixels.
- `i_frame_end` on the exact `pix_en` of `h_cnt`=1359 -> that wrap increments normally; snap happens on the next wrap.
- LOCKED, stop `i_frame_end` -> `o_locked` drops after 1496 line wraps; assert `reset_n`=0 mid-line -> all outputs 0 immediately (async).
